// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the multiply/divide controller.
// The optional divider is selected by the MULDIV_DIV_EN macro.
package muldiv_pkg;

  localparam int ITER_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

`ifdef MULDIV_DIV_EN
  // Quotient reported for a divide by zero; HI returns the dividend.
  localparam logic [31:0] LO_DIV0 = 32'hFFFF_FFFF;
`else
  // HI/LO reported for any divide when the divider is not built.
  localparam logic [31:0] HI_NODIV = 32'h0000_0000;
  localparam logic [31:0] LO_NODIV = 32'h0000_0000;
`endif

  // Magnitude of a source operand: two's-complement absolute value for
  // signed ops, raw value for unsigned ops. 0x8000_0000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational step of the shared iterative datapath.
// mode_i=0: radix-2 shift-add multiply, acc = {partial_hi, multiplier bits}.
// mode_i=1: restoring subtract-shift divide, acc = {remainder, quotient bits}
//           (divide step only present when MULDIV_DIV_EN is defined).
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic        mode_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [63:0] acc_o
);

  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  // Multiply: add the multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right with the carry entering at the top.
  always_comb begin
    mul_sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);
    mul_next = {mul_sum, acc_i[31:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [32:0] rem_sh;
  logic [33:0] trial;
  logic        ge;
  logic [63:0] div_next;

  // Divide: shift the next dividend bit into the remainder and keep the
  // trial subtraction when it does not borrow. The shifted remainder can
  // reach 33 bits, so the trial is done at 34 bits to see the borrow.
  always_comb begin
    rem_sh   = {acc_i[63:32], acc_i[31]};
    trial    = {1'b0, rem_sh} - {2'b00, operand_i};
    ge       = ~trial[33];
    div_next = {(ge ? trial[31:0] : rem_sh[31:0]), acc_i[30:0], ge};
  end

  assign acc_o = mode_i ? div_next : mul_next;
`else
  logic unused_mode;
  assign unused_mode = mode_i;
  assign acc_o       = mul_next;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencing controller for the shared multi-cycle MULT/MULTU/
// DIV/DIVU resource. Owns the FSM, iteration counter, sign correction and
// the HI/LO valid/ack handshake. Define MULDIV_DIV_EN to build the divider;
// without it divides complete immediately with HI=LO=0.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_src1,
  input  logic [31:0] op_src2,
  output logic        op_ready,
  input  logic        flush,
  output logic        res_valid,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  input  logic        res_ack,
  output logic        hilo_busy
);

  localparam int CNT_W = $clog2(ITER + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             op_ready_q, res_valid_q, hilo_busy_q;
  logic [31:0]      res_hi_q, res_lo_q;

  logic [63:0]      acc_q;
  logic [31:0]      opnd_q;
  logic             div_q;
  logic             neg_res_q;
`ifdef MULDIV_DIV_EN
  logic             neg_rem_q;
`endif

  logic             is_div, is_signed, imm_done;
  logic [63:0]      acc_step;

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  assign is_div    = (op_e'(op_code) == OP_DIV) || (op_e'(op_code) == OP_DIVU);
  assign is_signed = (op_e'(op_code) == OP_MULT) || (op_e'(op_code) == OP_DIV);

`ifdef MULDIV_DIV_EN
  assign imm_done = is_div && (op_src2 == 32'd0);
`else
  assign imm_done = is_div;
`endif

  muldiv_iter u_iter (
    .mode_i    (div_q),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (acc_step)
  );

  // Next-state selection; flush wins over everything except reset.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (op_valid) state_d = imm_done ? S_DONE : S_RUN;
        S_RUN:  if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (res_ack) state_d = S_IDLE;
      endcase
    end
  end

  // State, registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      hilo_busy_q <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_ready_q  <= (state_d == S_IDLE);
      res_valid_q <= (state_d == S_DONE);
      hilo_busy_q <= (state_d != S_IDLE);
      if (!flush) begin
        unique case (state_q)
          S_IDLE: if (op_valid) begin
            div_q     <= is_div;
            cnt_q     <= '0;
            acc_q     <= {32'h0, mag32(op_src1, is_signed)};
            opnd_q    <= mag32(op_src2, is_signed);
            neg_res_q <= is_signed & (op_src1[31] ^ op_src2[31]);
`ifdef MULDIV_DIV_EN
            neg_rem_q <= is_signed & op_src1[31];
            if (imm_done) begin
              res_hi_q <= op_src1;
              res_lo_q <= LO_DIV0;
            end
`else
            if (imm_done) begin
              res_hi_q <= HI_NODIV;
              res_lo_q <= LO_NODIV;
            end
`endif
          end
          S_RUN: begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CNT_W'(1);
          end
          S_FIX: begin
            {res_hi_q, res_lo_q} <= cond_neg64(acc_q, neg_res_q);
`ifdef MULDIV_DIV_EN
            if (div_q) begin
              res_lo_q <= cond_neg32(acc_q[31:0], neg_res_q);
              res_hi_q <= cond_neg32(acc_q[63:32], neg_rem_q);
            end
`endif
          end
          S_DONE: ;
        endcase
      end
    end
  end

  assign op_ready  = op_ready_q;
  assign res_valid = res_valid_q;
  assign hilo_busy = hilo_busy_q;
  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl. Expected HI/LO and the
// cycle of first res_valid are queued at issue; a monitor pops and compares.
module tb_muldiv_ctrl;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_src1 = '0;
  logic [31:0] op_src2 = '0;
  logic        op_ready;
  logic        flush = 1'b0;
  logic        res_valid;
  logic [31:0] res_hi, res_lo;
  logic        res_ack = 1'b0;
  logic        hilo_busy;

  muldiv_ctrl #(.ITER(ITER)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_src1(op_src1), .op_src2(op_src2), .op_ready(op_ready), .flush(flush),
    .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo),
    .res_ack(res_ack), .hilo_busy(hilo_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: HI/LO from plain signed/unsigned arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint p;
    int sa, sb, q, r;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'b01: return {32'h0, a} * {32'h0, b};
`ifdef MULDIV_DIV_EN
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a); sb = $signed(b);
        q = sa / sb; r = sa % sb;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
`else
      default: return 64'h0;
`endif
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
    if (op[1] && b == 0) return 1;
`else
    if (op[1]) return 1;
`endif
    return ITER + 2;
  endfunction

  // Monitor: first valid cycle pops the scoreboard; later valid cycles
  // must hold the same result and keep the interlock asserted.
  bit   in_done = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (!reset) begin
      if (res_valid) begin
        if (!in_done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 64'd1, 64'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("res_hi", {32'h0, res_hi}, {32'h0, cur.hi});
            chk("res_lo", {32'h0, res_lo}, {32'h0, cur.lo});
            chk("latency", 64'(cyc), 64'(cur.due));
          end
          in_done = 1;
        end else begin
          chk("hold_hi", {32'h0, res_hi}, {32'h0, cur.hi});
          chk("hold_lo", {32'h0, res_lo}, {32'h0, cur.lo});
          chk("hold_busy", {63'h0, hilo_busy}, 64'd1);
          chk("hold_ready", {63'h0, op_ready}, 64'd0);
        end
      end else begin
        in_done = 0;
      end
    end
  end

  // Issue an op at a negedge while the DUT is idle.
  task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input int lat);
    exp_t x;
    op_valid = 1'b1; op_code = op; op_src1 = a; op_src2 = b;
    x.hi = e[63:32]; x.lo = e[31:0]; x.due = cyc + lat;
    exp_q.push_back(x);
    @(negedge clk);
    op_valid = 1'b0;
    chk("accept_busy", {63'h0, hilo_busy}, 64'd1);
    chk("accept_ready", {63'h0, op_ready}, 64'd0);
  endtask

  // Wait for the result, hold it for 'hold' cycles with stray op_valid
  // pulses, then ack. Optionally pulse res_ack early while RUN.
  task automatic finish_op(input int hold, input bit early_ack);
    int n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
      res_ack = (early_ack && n == 3);
    end
    res_ack = 1'b0;
    if (n >= 200) begin
      chk("result_timeout", 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      op_valid = 1'($urandom % 2);
      op_code  = 2'($urandom % 4);
      op_src1  = $urandom;
      op_src2  = $urandom;
      @(negedge clk);
    end
    op_valid = 1'b0;
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    chk("ack_busy", {63'h0, hilo_busy}, 64'd0);
    chk("ack_ready", {63'h0, op_ready}, 64'd1);
    chk("ack_valid", {63'h0, res_valid}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  initial begin
    vec_t dir[$];
    int c0;
    logic [1:0]  op;
    logic [31:0] a, b;

    dir.push_back('{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    dir.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
`ifdef MULDIV_DIV_EN
    dir.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    dir.push_back('{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003});
    dir.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    dir.push_back('{2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF});
`else
    dir.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000});
    dir.push_back('{2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
`endif

    repeat (3) @(negedge clk);
    chk("rst_ready", {63'h0, op_ready}, 64'd1);
    chk("rst_valid", {63'h0, res_valid}, 64'd0);
    chk("rst_busy", {63'h0, hilo_busy}, 64'd0);
    chk("rst_hi", {32'h0, res_hi}, 64'd0);
    chk("rst_lo", {32'h0, res_lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors; the first is held 5 cycles in DONE.
    foreach (dir[i]) begin
      drive_op(dir[i].op, dir[i].a, dir[i].b, {dir[i].hi, dir[i].lo},
               lat_of(dir[i].op, dir[i].b));
      finish_op((i == 0) ? 5 : 0, 1'b0);
    end

    // Flush a MULT during cycle T+10; no result may appear.
    op_valid = 1'b1; op_code = 2'b00; op_src1 = 32'h0000_0005; op_src2 = 32'h0000_0007;
    c0 = cyc;
    @(negedge clk);
    op_valid = 1'b0;
    for (int i = 0; i < 50 && cyc != c0 + 10; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", {63'h0, op_ready}, 64'd1);
    chk("flush_busy", {63'h0, hilo_busy}, 64'd0);
    chk("flush_valid", {63'h0, res_valid}, 64'd0);
    drive_op(2'b01, 32'h0001_0000, 32'h0001_0000, model(2'b01, 32'h0001_0000, 32'h0001_0000),
             lat_of(2'b01, 32'h0001_0000));
    finish_op(0, 1'b0);

    // Flush coincident with op_valid in IDLE: not accepted.
    op_valid = 1'b1; flush = 1'b1; op_code = 2'b01;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_ready", {63'h0, op_ready}, 64'd1);
    chk("flush_idle_busy", {63'h0, hilo_busy}, 64'd0);
    repeat (3) @(negedge clk);

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom % 4);
      a  = pick();
      b  = pick();
      drive_op(op, a, b, model(op, a, b), lat_of(op, b));
      finish_op(int'($urandom % 4), (lat_of(op, b) > 10) && ($urandom % 3 == 0));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
